serial_transmitter: RTL and testbench
=====================================

# serial_transmitter

Parallel-in, serial-out framed transmitter: accepts a WIDTH-bit word over a send/ready handshake and shifts it out on a single line as start bit, data bits LSB first, optional even parity bit and stop bit, each held for DIV clocks. It is the transmit-side counterpart to the serial-in shift registers used for capture, and drives inter-block or off-chip serial links from a parallel datapath.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- DIV, 4, clock cycles per serial bit (≥1)
- PARITY, 1, 1 = append even parity bit, 0 = no parity bit
- clock  input  1  single clock; all state changes on posedge
- reset_L  input  1  synchronous, active-low reset, sampled on posedge clock
- data  input  WIDTH  word to transmit; sampled only on the acceptance edge
- send  input  1  request to transmit data
- ready  output  1  high when a new word can be accepted
- busy  output  1  high while a frame is being shifted out
- serial  output  1  serial line; idles high
- done  output  1  one-cycle pulse when a frame completes

## Operation
- All outputs registered. Reset values: ready=1, busy=0, serial=1, done=0, state IDLE, counters 0.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: serial=1, ready=1, busy=0. Acceptance edge = posedge with send=1 and ready=1: latch data into shift register, go to START.
- START: serial=0 for DIV cycles, then DATA.
- DATA: serial = shift_reg[0]; after DIV cycles shift right by one, increment bit counter; after WIDTH bits go to PAR if PARITY=1, else STOP.
- PAR: serial = XOR of the latched word (total ones over data+parity is even), DIV cycles, then STOP.
- STOP: serial=1 for DIV cycles, then IDLE with done=1 for exactly that first IDLE cycle.
- Divider counter counts 0..DIV-1 and wraps at every bit boundary; bit counter counts 0..WIDTH-1. With DIV=1 every bit lasts exactly one cycle.
- send while ready=0 is ignored; no queuing. data changes after acceptance have no effect on the frame in flight.
- send held high continuously: a new word is accepted in the done cycle; consecutive frames are separated by exactly one idle-high cycle.
- Reset low mid-frame: at that edge all outputs return to reset values (serial=1 in the next cycle), frame abandoned, no done pulse.
- Reset and send asserted together: reset wins, nothing accepted.

## Timing
- Let cycle 0 be the cycle after the acceptance edge; F = DIV*(2+WIDTH+PARITY) is the frame length.
- Cycles 0..DIV-1: serial=0 (start), ready=0, busy=1.
- Data bit i: cycles DIV*(1+i) .. DIV*(2+i)-1.
- Parity (if PARITY=1): cycles DIV*(1+WIDTH) .. DIV*(2+WIDTH)-1.
- Stop: last DIV cycles, ending at cycle F-1.
- Cycle F: ready=1, busy=0, done=1, serial=1. done is low in every other cycle.
- ready and busy are always complementary.
- Accept-to-first-start-bit latency: 1 cycle (start bit visible in cycle 0).

## Test plan
- Reset: hold reset_L=0 for 2 cycles with send=1 -> serial=1, ready=1, busy=0, done=0 throughout; nothing accepted.
- WIDTH=8, DIV=4, PARITY=1, send data=8'hA5 for one cycle -> serial 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, parity 0 for 4, stop 1 for 4; done=1 only at cycle 44.
- Same config, data=8'h01 -> parity bit 1; data=8'hFF -> parity 0; busy high cycles 0..43.
- send held high with data=8'h3C then 8'hC3 changed at done cycle -> second start bit at cycle 45 (one idle cycle), second frame carries 8'hC3; pulse send during busy with 8'h00 -> ignored.
- Reset_L=0 at cycle 20 of a frame -> next cycle serial=1, ready=1, busy=0, no done; fresh send afterward produces a complete correct frame.
- WIDTH=8, DIV=1, PARITY=0, data=8'h80 -> serial 0,0,0,0,0,0,0,0,1,1 over cycles 0..9; done=1 at cycle 10.

Source files
------------

// File: rtl/serial_transmitter.sv
// rtl/serial_transmitter.sv - framed parallel-in serial-out transmitter with optional even parity
module serial_transmitter #(
    parameter int WIDTH  = 8,
    parameter int DIV    = 4,
    parameter int PARITY = 1
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data,
    input  logic             send,
    output logic             ready,
    output logic             busy,
    output logic             serial,
    output logic             done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t           state, state_n;
    logic [DW-1:0]    div_cnt, div_cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shift_reg, shift_reg_n;
    logic             par_bit, par_bit_n;
    logic             ready_n, busy_n, serial_n, done_n;
    logic             bit_end;

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            serial    <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_reg_n;
            par_bit   <= par_bit_n;
            ready     <= ready_n;
            busy      <= busy_n;
            serial    <= serial_n;
            done      <= done_n;
        end
    end

    // Outputs are computed one cycle ahead so the line changes exactly on bit boundaries.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_reg_n = shift_reg;
        par_bit_n   = par_bit;
        ready_n     = ready;
        busy_n      = busy;
        serial_n    = serial;
        done_n      = 1'b0;
        bit_end     = (div_cnt == DW'(DIV - 1));
        div_cnt_n   = bit_end ? '0 : div_cnt + DW'(1);

        case (state)
            IDLE: begin
                div_cnt_n = '0;
                if (send && ready) begin
                    state_n     = START;
                    shift_reg_n = data;
                    par_bit_n   = ^data;
                    bit_cnt_n   = '0;
                    serial_n    = 1'b0;
                    ready_n     = 1'b0;
                    busy_n      = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n  = DATA;
                    serial_n = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        if (PARITY != 0) begin
                            state_n  = PAR;
                            serial_n = par_bit;
                        end else begin
                            state_n  = STOP;
                            serial_n = 1'b1;
                        end
                    end else begin
                        bit_cnt_n   = bit_cnt + BW'(1);
                        shift_reg_n = shift_reg >> 1;
                        serial_n    = shift_reg[1];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_n  = STOP;
                    serial_n = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n  = IDLE;
                    serial_n = 1'b1;
                    ready_n  = 1'b1;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                serial_n = 1'b1;
                ready_n  = 1'b1;
                busy_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// tb/tb_serial_transmitter.sv - randomized frame checks of serial_transmitter against a bit-list model
module tb_serial_transmitter;

    logic       clock = 1'b0;
    logic       reset_L;
    logic       send;
    logic       sel;
    logic [7:0] data;
    logic       ready_a, busy_a, serial_a, done_a;
    logic       ready_b, busy_b, serial_b, done_b;
    logic       send_a, send_b;
    logic       s_ready, s_busy, s_serial, s_done;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clock = ~clock;

    assign send_a   = send & ~sel;
    assign send_b   = send & sel;
    assign s_ready  = sel ? ready_b  : ready_a;
    assign s_busy   = sel ? busy_b   : busy_a;
    assign s_serial = sel ? serial_b : serial_a;
    assign s_done   = sel ? done_b   : done_a;

    serial_transmitter #(.WIDTH(8), .DIV(4), .PARITY(1)) dut_a (
        .clock(clock), .reset_L(reset_L), .data(data), .send(send_a),
        .ready(ready_a), .busy(busy_a), .serial(serial_a), .done(done_a)
    );

    serial_transmitter #(.WIDTH(8), .DIV(1), .PARITY(0)) dut_b (
        .clock(clock), .reset_L(reset_L), .data(data), .send(send_b),
        .ready(ready_b), .busy(busy_b), .serial(serial_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_serial"}, s_serial, 1);
        check({tag, "_ready"},  s_ready,  1);
        check({tag, "_busy"},   s_busy,   0);
        check({tag, "_done"},   s_done,   exp_done);
    endtask

    // Frame model: list of line levels, each held for the divider period.
    task automatic frame(input logic [7:0] w, input bit chain, input logic [7:0] nw, input bit pulses);
        int   dv;
        int   f;
        logic bits[$];
        dv = sel ? 1 : 4;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        if (!sel) bits.push_back(^w);
        bits.push_back(1'b1);
        f = dv * bits.size();
        check("ready_before", s_ready, 1);
        send = 1'b1;
        data = w;
        tick();
        send = 1'b0;
        data = 8'($urandom);
        for (int c = 0; c <= f; c++) begin
            if (c < f) begin
                check($sformatf("serial[%0d]", c), s_serial, bits[c / dv]);
                check($sformatf("busy[%0d]", c),   s_busy,   1);
                check($sformatf("ready[%0d]", c),  s_ready,  0);
                check($sformatf("done[%0d]", c),   s_done,   0);
                send = pulses && ($urandom_range(0, 3) == 0);
                data = 8'($urandom);
                tick();
            end else begin
                check_idle($sformatf("end[%0d]", c), 1);
                send = chain;
                data = nw;
            end
        end
    endtask

    initial begin
        sel     = 1'b0;
        send    = 1'b1;
        data    = 8'hFF;
        reset_L = 1'b0;
        tick();
        check_idle("rst0", 0);
        check("rst0_b_ready", ready_b, 1);
        tick();
        check_idle("rst1", 0);
        check("rst1_b_serial", serial_b, 1);
        send    = 1'b0;
        reset_L = 1'b1;
        tick();
        check_idle("post_rst", 0);

        frame(8'hA5, 0, 8'h00, 0);
        tick();
        check_idle("gap", 0);
        frame(8'h01, 0, 8'h00, 0);
        frame(8'hFF, 0, 8'h00, 1);
        tick();

        frame(8'h3C, 1, 8'hC3, 1);
        frame(8'hC3, 0, 8'h00, 1);
        tick();

        send = 1'b1;
        data = 8'h5A;
        tick();
        send = 1'b0;
        repeat (20) tick();
        reset_L = 1'b0;
        tick();
        check_idle("midrst", 0);
        reset_L = 1'b1;
        repeat (3) begin
            tick();
            check_idle("after_midrst", 0);
        end
        frame(8'h96, 0, 8'h00, 0);
        tick();

        for (int k = 0; k < 8; k++) begin
            frame(8'($urandom), ($urandom_range(0, 1) == 1), 8'($urandom), 1);
            send = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end

        sel = 1'b1;
        tick();
        check_idle("b_idle", 0);
        frame(8'h80, 0, 8'h00, 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            frame(8'($urandom), 0, 8'h00, 1);
            send = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
